// File: rtl/data_sync_hs_if.sv
// Handshake bundle between an asynchronous toggle-request source, the receive-side
// synchronizer, and its downstream consumer. Signal suffixes follow the synchronizer's view.
interface data_sync_hs_if #(
    parameter int BUS_WIDTH = 8
) ();
    logic [BUS_WIDTH-1:0] unsync_bus_i;
    logic                 req_tgl_i;
    logic                 ack_tgl_o;
    logic [BUS_WIDTH-1:0] sync_bus_o;
    logic                 sync_valid_o;
    logic                 sync_ready_i;
    logic                 proto_err_o;

    modport slave (
        input  unsync_bus_i,
        input  req_tgl_i,
        input  sync_ready_i,
        output ack_tgl_o,
        output sync_bus_o,
        output sync_valid_o,
        output proto_err_o
    );

    modport master (
        output unsync_bus_i,
        output req_tgl_i,
        output sync_ready_i,
        input  ack_tgl_o,
        input  sync_bus_o,
        input  sync_valid_o,
        input  proto_err_o
    );
endinterface

// File: rtl/data_sync_hs.sv
// Toggle-handshake bus synchronizer: only the request toggle crosses through a flop chain;
// the data bus is captured whole once the synchronized toggle edge is seen.
module data_sync_hs #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    data_sync_hs_if.slave      bus
);
    localparam int CNT_W = $clog2(NUM_STAGES + 1);

    localparam logic [1:0] ST_WARMUP = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic                 sync_q [NUM_STAGES];
    logic                 sync_d [NUM_STAGES];
    logic                 req_prev_q, req_prev_d;
    logic [CNT_W-1:0]     warm_cnt_q, warm_cnt_d;
    logic [1:0]           state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 valid_q, valid_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 err_q, err_d;

    logic req_sync;
    logic req_sync_next;
    logic req_edge;
    logic warm_last;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = bus.req_tgl_i;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign req_sync      = sync_q[NUM_STAGES-1];
    // Level that req_sync takes after the coming edge; used to seed state while warming up.
    assign req_sync_next = sync_q[NUM_STAGES-2];
    assign req_edge      = req_sync ^ req_prev_q;
    assign warm_last     = (warm_cnt_q == CNT_W'(NUM_STAGES - 1));

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        req_prev_d = req_sync;
        ack_d      = ack_q;
        valid_d    = valid_q;
        data_d     = data_q;
        err_d      = err_q;

        case (state_q)
            ST_WARMUP: begin
                // The chain was cleared by reset and is still filling; tracking the
                // look-ahead level means a level held across reset never looks like an edge.
                req_prev_d = req_sync_next;
                warm_cnt_d = warm_cnt_q + CNT_W'(1);
                if (warm_last) begin
                    ack_d   = req_sync_next;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_edge) begin
                    data_d  = bus.unsync_bus_i;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (req_edge) begin
                    err_d = 1'b1;
                end
                if (valid_q && bus.sync_ready_i) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                sync_q[i] <= 1'b0;
            end
            req_prev_q <= 1'b0;
            warm_cnt_q <= '0;
            state_q    <= ST_WARMUP;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            req_prev_q <= req_prev_d;
            warm_cnt_q <= warm_cnt_d;
            state_q    <= state_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    assign bus.ack_tgl_o    = ack_q;
    assign bus.sync_bus_o   = data_q;
    assign bus.sync_valid_o = valid_q;
    assign bus.proto_err_o  = err_q;
endmodule
